// File: rtl/therm2bin_multi.sv
// therm2bin_multi: N-lane thermometer-to-binary converter (binary search, then 16-bit popcount).
// Latency B-2 (B-1 with THERM2BIN_BUBBLE_FIX_EN majority filter); global stall, in_ready = !out_valid || out_ready.
module therm2bin_multi #(
  parameter int B = 8,
  parameter int N = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*(2**B-1)-1:0]  thermo,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*B-1:0]         bin,
  output logic [N-1:0]           sat,
  output logic [N-1:0]           bubble_err
);

  localparam int W = 2**B;  // thermometer padded with a zero top bit
  localparam int P = B-4;   // search stages; leaves a 16-bit window

  typedef struct packed {
    logic [W-1:0] win;
    logic [B-1:0] cnt;
    logic         sat;
    logic         bub;
  } ch_t;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic ch_t capture(input logic [W-2:0] t);
    ch_t c;
    c.win = {1'b0, t};
    c.cnt = '0;
    c.sat = &t;
    c.bub = |(t[W-2:1] & ~t[W-3:0]);
    return c;
  endfunction

  // Top bit of the lower half set means the whole lower half is ones.
  function automatic ch_t search(input ch_t s, input int half);
    ch_t c;
    logic [W-1:0] mask;
    mask = {W{1'b1}} >> (W - half);
    c = s;
    if (s.win[half-1]) begin
      c.win = (s.win >> half) & mask;
      c.cnt = s.cnt + B'(half);
    end else begin
      c.win = s.win & mask;
    end
    return c;
  endfunction

  function automatic logic [B-1:0] pop16(input logic [15:0] w);
    logic [B-1:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + B'(w[i]);
    return n;
  endfunction

`ifdef THERM2BIN_BUBBLE_FIX_EN
  // Neighbour majority; implicit 1 below bit 0 and 0 above the top bit.
  function automatic ch_t bfix(input ch_t s);
    ch_t c;
    logic [W-1:0] t, lo, hi;
    t = s.win;
    lo = {t[W-2:0], 1'b1};
    hi = {1'b0, t[W-1:1]};
    c = s;
    c.win = (t & lo) | (t & hi) | (lo & hi);
    return c;
  endfunction

  ch_t  cap [N];
  logic cap_vld;
`endif

  ch_t        pipe [P+1][N];
  logic [P:0] pv;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv <= '0;
      for (int j = 0; j <= P; j++)
        for (int c = 0; c < N; c++) pipe[j][c] <= '0;
`ifdef THERM2BIN_BUBBLE_FIX_EN
      cap_vld <= 1'b0;
      for (int c = 0; c < N; c++) cap[c] <= '0;
`endif
      out_valid  <= 1'b0;
      bin        <= '0;
      sat        <= '0;
      bubble_err <= '0;
    end else if (adv) begin
`ifdef THERM2BIN_BUBBLE_FIX_EN
      cap_vld <= in_valid;
      pv[0]   <= cap_vld;
      for (int c = 0; c < N; c++) begin
        cap[c]     <= capture(thermo[c*(W-1) +: W-1]);
        pipe[0][c] <= bfix(cap[c]);
      end
`else
      pv[0] <= in_valid;
      for (int c = 0; c < N; c++) pipe[0][c] <= capture(thermo[c*(W-1) +: W-1]);
`endif
      for (int j = 1; j <= P; j++) begin
        pv[j] <= pv[j-1];
        for (int c = 0; c < N; c++) pipe[j][c] <= search(pipe[j-1][c], W >> j);
      end
      out_valid <= pv[P];
      // Results only move on a valid slot so the outputs hold while idle.
      if (pv[P]) begin
        for (int c = 0; c < N; c++) begin
          bin[c*B +: B] <= pipe[P][c].cnt + pop16(pipe[P][c].win[15:0]);
          sat[c]        <= pipe[P][c].sat;
          bubble_err[c] <= pipe[P][c].bub;
        end
      end
    end
  end

endmodule

// File: tb/tb_therm2bin_multi.sv
// Scoreboard bench for therm2bin_multi with B=8, N=2.
module tb_therm2bin_multi;
  localparam int B  = 8;
  localparam int N  = 2;
  localparam int TW = 255;
`ifdef THERM2BIN_BUBBLE_FIX_EN
  localparam int  LAT = 7;
  localparam logic FIX = 1'b1;
`else
  localparam int  LAT = 6;
  localparam logic FIX = 1'b0;
`endif

  typedef struct {
    logic [15:0] bin;
    logic [1:0]  sat;
    logic [1:0]  bub;
    logic        bin_chk;
    logic        lat_chk;
    int          cyc;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [N*TW-1:0]   thermo;
  logic              out_valid;
  logic              out_ready;
  logic [N*B-1:0]    bin;
  logic [N-1:0]      sat;
  logic [N-1:0]      bubble_err;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  therm2bin_multi #(.B(B), .N(N)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .thermo(thermo), .out_valid(out_valid), .out_ready(out_ready),
    .bin(bin), .sat(sat), .bubble_err(bubble_err)
  );

  always #5 clock = ~clock;

  function automatic logic [N*TW-1:0] mk(input int n0, input int n1);
    logic [N*TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i++) begin
      t[i]      = (i < n0);
      t[TW + i] = (i < n1);
    end
    return t;
  endfunction

  function automatic exp_t clean(input int n0, input int n1, input logic lat_chk);
    exp_t e;
    e.bin     = {8'(n1), 8'(n0)};
    e.sat     = {n1 == 255, n0 == 255};
    e.bub     = 2'b00;
    e.bin_chk = 1'b1;
    e.lat_chk = lat_chk;
    e.cyc     = 0;
    return e;
  endfunction

  // One clock cycle: drive, observe, queue the expectation if accepted.
  task automatic tick(input logic v, input logic [N*TW-1:0] th, input exp_t e, input logic ordy,
                      output logic acc, output logic xfer, output logic ov, output logic ir,
                      output logic [15:0] ob, output logic [1:0] os, output logic [1:0] oe,
                      output int oc);
    exp_t ee;
    in_valid  = v;
    thermo    = th;
    out_ready = ordy;
    #1;
    acc  = v && in_ready;
    ir   = in_ready;
    ov   = out_valid;
    xfer = out_valid && ordy;
    ob   = bin;
    os   = sat;
    oe   = bubble_err;
    oc   = cyc;
    if (acc) begin
      ee = e;
      ee.cyc = cyc;
      exp_q.push_back(ee);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; thermo = '0; out_ready = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin !== 16'h0 || sat !== 2'b0 || bubble_err !== 2'b0) begin
      miscompares++;
      $display("FAIL reset got ov=%b ir=%b bin=%h sat=%b bub=%b want ov=0 ir=1 bin=0000 sat=00 bub=00",
               out_valid, in_ready, bin, sat, bubble_err);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_clean_sat();
    int n0s [7] = '{0, 255, 1, 255, 128, 16, 17};
    int n1s [7] = '{100, 1, 255, 255, 127, 15, 0};
    logic acc, xfer, ov, ir; logic [15:0] ob; logic [1:0] os, oe; int oc; exp_t e;
    for (int k = 0; k < 30 && (k < 7 || exp_q.size() > 0); k++) begin
      if (k < 7) tick(1'b1, mk(n0s[k], n1s[k]), clean(n0s[k], n1s[k], 1'b1), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      else       tick(1'b0, '0, clean(0, 0, 1'b1), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      if (k == 0) begin
        vectors++;
        if (acc !== 1'b1) begin miscompares++; $display("FAIL first_accept got %b want 1", acc); end
      end
      if (xfer) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL clean_extra got bin=%h want no output", ob);
        end else begin
          e = exp_q.pop_front();
          if ((e.bin_chk && ob !== e.bin) || os !== e.sat || oe !== e.bub || (e.lat_chk && oc - e.cyc != LAT)) begin
            miscompares++;
            $display("FAIL clean got bin=%h sat=%b bub=%b lat=%0d want bin=%h sat=%b bub=%b lat=%0d",
                     ob, os, oe, oc - e.cyc, e.bin, e.sat, e.bub, LAT);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL clean_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_bubble();
    logic [N*TW-1:0] th [2];
    exp_t ex [2];
    logic acc, xfer, ov, ir; logic [15:0] ob; logic [1:0] os, oe; int oc; exp_t e;
    th[0] = mk(40, 3); th[0][20] = 1'b0;
    ex[0] = clean(40, 3, 1'b1); ex[0].bub = 2'b01; ex[0].bin_chk = FIX;
    th[1] = mk(5, 10); th[1][TW + 50] = 1'b1;
    ex[1] = clean(5, 10, 1'b1); ex[1].bub = 2'b10; ex[1].bin_chk = FIX;
    for (int k = 0; k < 30 && (k < 2 || exp_q.size() > 0); k++) begin
      if (k < 2) tick(1'b1, th[k], ex[k], 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      else       tick(1'b0, '0, ex[0], 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      if (xfer) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bubble_extra got bin=%h want no output", ob);
        end else begin
          e = exp_q.pop_front();
          if ((e.bin_chk && ob !== e.bin) || os !== e.sat || oe !== e.bub || (e.lat_chk && oc - e.cyc != LAT)) begin
            miscompares++;
            $display("FAIL bubble got bin=%h sat=%b bub=%b lat=%0d want bin=%h sat=%b bub=%b lat=%0d",
                     ob, os, oe, oc - e.cyc, e.bin, e.sat, e.bub, LAT);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL bubble_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int recv = 0;
    logic ordy;
    logic [15:0] held;
    logic acc, xfer, ov, ir; logic [15:0] ob; logic [1:0] os, oe; int oc; exp_t e;
    held = '0;
    for (int k = 0; k < 40 && (idx < 10 || exp_q.size() > 0); k++) begin
      ordy = !(k >= 7 && k <= 9);
      tick(idx < 10, mk(idx + 10, 2*idx + 1), clean(idx + 10, 2*idx + 1, 1'b0), ordy,
           acc, xfer, ov, ir, ob, os, oe, oc);
      if (acc) idx++;
      if (!ordy) begin
        vectors++;
        if (ir !== 1'b0 || ov !== 1'b1) begin
          miscompares++; $display("FAIL stall_ready got ir=%b ov=%b want ir=0 ov=1", ir, ov);
        end
        if (k > 7) begin
          vectors++;
          if (ob !== held) begin miscompares++; $display("FAIL stall_hold got bin=%h want %h", ob, held); end
        end
        held = ob;
      end
      if (xfer) begin
        vectors++;
        recv++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_extra got bin=%h want no output", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e.bin || os !== e.sat || oe !== e.bub) begin
            miscompares++;
            $display("FAIL backpressure got bin=%h sat=%b bub=%b want bin=%h sat=%b bub=%b",
                     ob, os, oe, e.bin, e.sat, e.bub);
          end
        end
      end
    end
    vectors++;
    if (recv != 10 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL bp_count got %0d results (%0d pending) want 10", recv, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, xfer, ov, ir; logic [15:0] ob; logic [1:0] os, oe; int oc; exp_t e;
    for (int k = 0; k < 3; k++)
      tick(1'b1, mk(k + 1, k + 2), clean(k + 1, k + 2, 1'b0), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, '0, clean(0, 0, 1'b0), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      vectors++;
      if (ov !== 1'b0) begin miscompares++; $display("FAIL no_stale got ov=%b bin=%h want ov=0", ov, ob); end
    end
    for (int k = 0; k < 30 && (k < 1 || exp_q.size() > 0); k++) begin
      if (k == 0) tick(1'b1, mk(7, 0), clean(7, 0, 1'b1), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      else        tick(1'b0, '0, clean(0, 0, 1'b0), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      if (xfer) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL post_reset_extra got bin=%h want no output", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e.bin || os !== e.sat || oe !== e.bub || oc - e.cyc != LAT) begin
            miscompares++;
            $display("FAIL post_reset got bin=%h lat=%0d want bin=%h lat=%0d", ob, oc - e.cyc, e.bin, LAT);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL post_reset_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int recv = 0;
    logic acc, xfer, ov, ir; logic [15:0] ob; logic [1:0] os, oe; int oc; exp_t e;
    for (int k = 0; k < 300 && (idx < 255 || exp_q.size() > 0); k++) begin
      tick(idx < 255, mk(idx, 254 - idx), clean(idx, 254 - idx, 1'b1), 1'b1,
           acc, xfer, ov, ir, ob, os, oe, oc);
      if (idx < 255) begin
        vectors++;
        if (acc !== 1'b1) begin miscompares++; $display("FAIL b2b_accept idx=%0d got %b want 1", idx, acc); end
        idx++;
      end
      if (xfer) begin
        vectors++;
        recv++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra got bin=%h want no output", ob);
        end else begin
          e = exp_q.pop_front();
          if (ob !== e.bin || os !== e.sat || oe !== e.bub || oc - e.cyc != LAT) begin
            miscompares++;
            $display("FAIL b2b got bin=%h sat=%b lat=%0d want bin=%h sat=%b lat=%0d",
                     ob, os, oc - e.cyc, e.bin, e.sat, LAT);
          end
        end
      end
    end
    vectors++;
    if (recv != 255 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_count got %0d results want 255", recv);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, clean(0, 0, 1'b0), 1'b1, acc, xfer, ov, ir, ob, os, oe, oc);
      vectors++;
      if (ov !== 1'b0 || ob !== {8'd0, 8'd254}) begin
        miscompares++; $display("FAIL idle_hold got ov=%b bin=%h want ov=0 bin=00fe", ov, ob);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_sat();
    test_bubble();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/therm2bin_multi.md
THERM2BIN_MULTI -- requirements
Module: therm2bin_multi

Interface
REQ-001 SHALL have parameter B, default 8, meaning output bits per channel (legal range 5..10).
REQ-002 SHALL have parameter N, default 4, meaning the number of independent channels converted in lockstep.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  thermo holds a sample to accept.
REQ-006 SHALL have port in_ready  output  1  the block accepts a sample this cycle.
REQ-007 SHALL have port thermo  input  N*(2^B-1)  channel c in bits [c*(2^B-1) +: 2^B-1]; bit 0 is the lowest level.
REQ-008 SHALL have port out_valid  output  1  bin, sat and bubble_err hold a result.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port bin  output  N*B  channel c binary count in bits [c*B +: B].
REQ-011 SHALL have port sat  output  N  channel input was all ones (bin = 2^B-1).
REQ-012 SHALL have port bubble_err  output  N  raw channel input was not a clean thermometer code (a 1 exists above a 0).

Function
REQ-013 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-014 SHALL compute bin per channel by a pipelined binary search:
- B-4 registered stages, each testing the midpoint of the remaining window, then selecting the upper or lower half;
- followed by a registered popcount of the final 16-bit window.
REQ-015 SHALL produce bin equal to the number of ones for every clean thermometer code, 0..2^B-1.
REQ-016 SHALL give a latency of exactly B-2 cycles from acceptance to out_valid when never stalled (B-1 with BUBBLE_FIX_EN).
REQ-017 SHALL accept one sample per cycle at full throughput while out_ready is high.
REQ-018 SHALL use a global stall: in_ready = !out_valid || out_ready.
REQ-019 SHALL, while stalled, hold every stage, valid bit, bin, sat and bubble_err unchanged.
REQ-020 SHALL carry a valid bit per stage; bubbles (invalid slots) shall collapse only when downstream is ready.
REQ-021 SHALL hold bin, sat and bubble_err at their last values while out_valid is low; outputs are not zeroed.
REQ-022 SHALL compute sat and bubble_err from the raw input at acceptance and pipeline them alongside bin.
REQ-023 SHALL treat non-thermometer inputs without BUBBLE_FIX_EN as follows: bin is the binary-search result and is not required to equal the popcount; bubble_err is still flagged.

Reset
REQ-024 SHALL, while reset_n is low, asynchronously clear all stage valid bits, out_valid, bin, sat and bubble_err to 0.
REQ-025 SHALL drive in_ready to 1 during and after reset.
REQ-026 SHALL discard any in-flight samples on reset; no result for them shall appear after release.
REQ-027 SHALL accept a new sample on the first rising edge after reset_n rises.

Configuration
REQ-028 SHALL honour macro THERM2BIN_BUBBLE_FIX_EN as the only compile-time option.
REQ-029 SHALL, when THERM2BIN_BUBBLE_FIX_EN is defined:
- insert one registered 3-input majority filter stage before the search;
- filter each bit as t'[i] = maj(t[i-1], t[i], t[i+1]), with t[-1] = 1 and t[2^B-1] = 0;
- increase latency by 1.
REQ-030 SHALL, when THERM2BIN_BUBBLE_FIX_EN is undefined, omit the filter stage, with latency B-2 and no filter logic.

Verification (B=8, N=2, out_ready=1 unless stated)
REQ-031 SHALL verify clean codes: ch0 = 0 ones, ch1 = 100 ones, accepted at cycle t -> out_valid at t+6, bin ch0 = 0, ch1 = 100, sat = 00, bubble_err = 00.
REQ-032 SHALL verify saturation: ch0 all 255 ones, ch1 = 1 one -> bin ch0 = 255, ch1 = 1, sat = 01 (ch0 set).
REQ-033 SHALL verify backpressure: a stream of 10 counting samples with out_ready low for 3 cycles mid-stream -> in_ready low those cycles, no sample lost or duplicated, outputs held, order preserved.
REQ-034 SHALL verify bubble correction with macro: ch0 = 40 ones with bit 20 cleared -> bin ch0 = 40, bubble_err ch0 = 1, latency 7.
REQ-035 SHALL verify reset mid-flight: 3 samples accepted, reset_n pulsed low at cycle 2 -> out_valid stays 0 and no stale result appears; a new sample of 7 ones -> bin 7 after 6 cycles.
REQ-036 SHALL verify full throughput: back-to-back samples 0..254 for ch0 -> one result per cycle, bin equals the input index in order.
